// File: rtl/contador_pkg.sv
// Shared types and defaults for the contador counter and its downstream monitor.
package contador_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StLocked  = 2'd2,
        StLost    = 2'd3
    } monitor_state_t;

    localparam int unsigned DefaultWidth   = 4;
    localparam int unsigned DefaultLockCnt = 3;
    localparam int unsigned DefaultLossCnt = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/contador_monitor.sv
// Checks that a sampled count stream increments by one per valid sample, tracking lock,
// sequence errors, wraps and upstream restarts.
module contador_monitor
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter int unsigned LOCK_CNT = DefaultLockCnt,
    parameter int unsigned LOSS_CNT = DefaultLossCnt,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_valid,
    output logic              locked,
    output logic              seq_error,
    output logic              wrap_pulse,
    output logic              restart_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [1:0]        state
);

    localparam int unsigned RunW  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MissW = $clog2(LOSS_CNT + 1);

    monitor_state_t   state_d, state_q;
    logic [WIDTH-1:0] prev_d, prev_q;
    logic [RunW-1:0]  run_d, run_q;
    logic [MissW-1:0] miss_d, miss_q;
    logic             seq_error_d, seq_error_q;
    logic             wrap_d, wrap_q;
    logic             restart_d, restart_q;

    logic [WIDTH-1:0] expected;
    logic [RunW-1:0]  run_inc;
    logic [MissW-1:0] miss_inc;
    logic             is_correct;
    logic             is_restart;

    assign expected   = prev_q + 1'b1;
    assign run_inc    = run_q + 1'b1;
    assign miss_inc   = miss_q + 1'b1;
    assign is_correct = (count_in == expected);
    // A zero that the sequence predicted is a wrap, not a restart.
    assign is_restart = (count_in == '0) && (expected != '0);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        run_d       = run_q;
        miss_d      = miss_q;
        seq_error_d = 1'b0;
        wrap_d      = 1'b0;
        restart_d   = 1'b0;
        if (count_valid) begin
            prev_d = count_in;
            if (state_q == StIdle) begin
                state_d = StAcquire;
                run_d   = '0;
            end else if (is_restart) begin
                restart_d = 1'b1;
                state_d   = StAcquire;
                run_d     = '0;
                miss_d    = '0;
            end else if (is_correct) begin
                wrap_d = (prev_q == '1);
                if (state_q == StLocked) begin
                    miss_d = '0;
                end else if (run_inc == RunW'(LOCK_CNT)) begin
                    state_d = StLocked;
                    run_d   = '0;
                    miss_d  = '0;
                end else begin
                    run_d = run_inc;
                end
            end else begin
                seq_error_d = 1'b1;
                if (state_q == StLocked) begin
                    if (miss_inc == MissW'(LOSS_CNT)) begin
                        state_d = StLost;
                        run_d   = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end else begin
                    run_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            prev_q      <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            seq_error_q <= 1'b0;
            wrap_q      <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            seq_error_q <= seq_error_d;
            wrap_q      <= wrap_d;
            restart_q   <= restart_d;
        end
    end

    // Counters step on the same edge their pulse registers.
    sat_counter #(
        .W (ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (seq_error_d),
        .count (err_count)
    );

    sat_counter #(
        .W (WRAP_W)
    ) u_wrap_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_d),
        .count (wrap_count)
    );

    assign locked        = (state_q == StLocked);
    assign seq_error     = seq_error_q;
    assign wrap_pulse    = wrap_q;
    assign restart_pulse = restart_q;
    assign state         = state_q;

endmodule

// File: tb/tb_contador_monitor.sv
// Directed bench for contador_monitor with hand-computed expectations.
module tb_contador_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] count_in;
    logic       count_valid;
    logic       locked;
    logic       seq_error;
    logic       wrap_pulse;
    logic       restart_pulse;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic [1:0] state;

    int checks;
    int errors;
    int wraps;

    localparam logic [1:0] SIdle = 2'd0;
    localparam logic [1:0] SAcq  = 2'd1;
    localparam logic [1:0] SLock = 2'd2;
    localparam logic [1:0] SLost = 2'd3;

    contador_monitor dut (
        .clk           (clk),
        .reset         (reset),
        .count_in      (count_in),
        .count_valid   (count_valid),
        .locked        (locked),
        .seq_error     (seq_error),
        .wrap_pulse    (wrap_pulse),
        .restart_pulse (restart_pulse),
        .err_count     (err_count),
        .wrap_count    (wrap_count),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sample(input logic v, input logic [3:0] c);
        count_valid = v;
        count_in    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [1:0] st, input logic se,
                              input logic wp, input logic rp, input logic [7:0] ec,
                              input logic [7:0] wc);
        logic lk;
        lk = (st == SLock);
        checks += 7;
        assert (state === st) else begin
            errors++;
            $error("FAIL %s.state observed=%0d expected=%0d", tag, state, st);
        end
        assert (locked === lk) else begin
            errors++;
            $error("FAIL %s.locked observed=%0b expected=%0b", tag, locked, lk);
        end
        assert (seq_error === se) else begin
            errors++;
            $error("FAIL %s.seq_error observed=%0b expected=%0b", tag, seq_error, se);
        end
        assert (wrap_pulse === wp) else begin
            errors++;
            $error("FAIL %s.wrap_pulse observed=%0b expected=%0b", tag, wrap_pulse, wp);
        end
        assert (restart_pulse === rp) else begin
            errors++;
            $error("FAIL %s.restart_pulse observed=%0b expected=%0b", tag, restart_pulse, rp);
        end
        assert (err_count === ec) else begin
            errors++;
            $error("FAIL %s.err_count observed=%0d expected=%0d", tag, err_count, ec);
        end
        assert (wrap_count === wc) else begin
            errors++;
            $error("FAIL %s.wrap_count observed=%0d expected=%0d", tag, wrap_count, wc);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        wraps       = 0;
        reset       = 1'b0;
        count_valid = 1'b0;
        count_in    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        expect_all("reset", SIdle, 0, 0, 0, 8'd0, 8'd0);
        reset = 1'b1;

        // Acquire and lock on 0,1,2,3
        sample(1'b1, 4'd0);
        expect_all("idle_first", SAcq, 0, 0, 0, 8'd0, 8'd0);
        sample(1'b1, 4'd1);
        expect_all("acq1", SAcq, 0, 0, 0, 8'd0, 8'd0);
        sample(1'b1, 4'd2);
        expect_all("acq2", SAcq, 0, 0, 0, 8'd0, 8'd0);
        sample(1'b1, 4'd3);
        expect_all("lock", SLock, 0, 0, 0, 8'd0, 8'd0);

        // Sweep through max->0
        for (int v = 4; v < 16; v++) begin
            sample(1'b1, 4'(v));
            wraps += int'(wrap_pulse);
        end
        expect_all("at_max", SLock, 0, 0, 0, 8'd0, 8'd0);
        sample(1'b1, 4'd0);
        wraps += int'(wrap_pulse);
        expect_all("wrap", SLock, 0, 1, 0, 8'd0, 8'd1);
        sample(1'b1, 4'd1);
        wraps += int'(wrap_pulse);
        expect_all("post_wrap", SLock, 0, 0, 0, 8'd0, 8'd1);
        chk_int("wrap_pulse_total", wraps, 1);

        // Single glitch while locked
        sample(1'b1, 4'd2);
        sample(1'b1, 4'd3);
        sample(1'b1, 4'd4);
        sample(1'b1, 4'd9);
        expect_all("glitch", SLock, 1, 0, 0, 8'd1, 8'd1);
        sample(1'b1, 4'd10);
        expect_all("glitch_resync", SLock, 0, 0, 0, 8'd1, 8'd1);
        sample(1'b1, 4'd11);
        expect_all("glitch_after", SLock, 0, 0, 0, 8'd1, 8'd1);

        // Two consecutive misses -> LOST, three correct -> relock
        sample(1'b1, 4'd12);
        expect_all("pre_loss", SLock, 0, 0, 0, 8'd1, 8'd1);
        sample(1'b1, 4'd3);
        expect_all("miss1", SLock, 1, 0, 0, 8'd2, 8'd1);
        sample(1'b1, 4'd7);
        expect_all("miss2", SLost, 1, 0, 0, 8'd3, 8'd1);
        sample(1'b1, 4'd8);
        expect_all("lost_run1", SLost, 0, 0, 0, 8'd3, 8'd1);
        sample(1'b1, 4'd9);
        expect_all("lost_run2", SLost, 0, 0, 0, 8'd3, 8'd1);
        sample(1'b1, 4'd10);
        expect_all("relock", SLock, 0, 0, 0, 8'd3, 8'd1);

        // Hold cycles then a restart to 0
        for (int i = 0; i < 3; i++) begin
            sample(1'b0, 4'd0);
            expect_all("hold", SLock, 0, 0, 0, 8'd3, 8'd1);
        end
        sample(1'b1, 4'd0);
        expect_all("restart", SAcq, 0, 0, 1, 8'd3, 8'd1);

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        expect_all("async_reset", SIdle, 0, 0, 0, 8'd0, 8'd0);
        @(negedge clk);
        reset = 1'b1;

        // Saturation of err_count
        sample(1'b1, 4'd5);
        expect_all("sat_start", SAcq, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 0; i < 300; i++) begin
            sample(1'b1, 4'd5);
            if (i == 253) begin
                chk_int("err_254", int'(err_count), 254);
            end
        end
        expect_all("sat", SAcq, 1, 0, 0, 8'd255, 8'd0);
        sample(1'b0, 4'd5);
        expect_all("sat_hold", SAcq, 0, 0, 0, 8'd255, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_monitor.md
Name: contador_monitor

Overview:
Downstream checker for contador_sequencial. It samples the 4-bit count stream on each valid clock and checks that every sample is the previous value +1 (mod 2^WIDTH). It tracks lock to the sequence, counts sequence errors and wrap-arounds, and flags upstream restarts. Its status outputs feed the board LEDs and the self-starter bring-up logic.

Parameters:
WIDTH, 4, width of the monitored count
LOCK_CNT, 3, consecutive correct increments needed to (re)enter LOCKED
LOSS_CNT, 2, consecutive mismatches in LOCKED that force LOST
ERR_W, 8, width of the saturating error counter
WRAP_W, 8, width of the saturating wrap counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
count_in  input  WIDTH  count from contador_sequencial
count_valid  input  1  count_in is sampled only when this is 1
locked  output  1  1 while the FSM is in LOCKED
seq_error  output  1  one-cycle pulse on a counted mismatch
wrap_pulse  output  1  one-cycle pulse on a correct max->0 transition
restart_pulse  output  1  one-cycle pulse on an unexpected jump to 0
err_count  output  ERR_W  saturating count of mismatches
wrap_count  output  WRAP_W  saturating count of wraps
state  output  2  FSM state: IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3

Behaviour:
- Reset:
  - reset low asynchronously clears every output, the prev register, the run counter and the miss counter.
  - state returns to IDLE.
  - After release, the block resumes on the next rising clk.
- Sampling:
  - All outputs are registered and update on the clk edge that samples count_in.
  - count_valid=0 means a hold cycle: no comparison, no pulses, state and counters unchanged.
- Definitions:
  - expected = prev+1, truncated to WIDTH bits.
  - correct: count_in==expected.
  - restart: count_in==0 and expected!=0.
  - mismatch: any other value.
- IDLE: the first valid sample loads prev, sets run=0 and moves to ACQUIRE. No pulses.
- ACQUIRE / LOST:
  - correct -> run++. When run reaches LOCK_CNT -> LOCKED, run=0, miss=0.
  - mismatch -> seq_error, err_count++, run=0, state unchanged.
- LOCKED:
  - correct -> miss=0.
  - mismatch -> seq_error, err_count++, miss++. When miss reaches LOSS_CNT -> LOST, run=0.
- Restart (any state except IDLE):
  - restart_pulse; no error; err_count unchanged.
  - state -> ACQUIRE, run=0, miss=0.
- Wrap:
  - A correct transition from 2^WIDTH-1 to 0 asserts wrap_pulse and increments wrap_count.
  - This is a correct sample, so it also advances run as usual.
- Every valid sample loads prev=count_in, including mismatches, so checking resynchronises to the new value.
- Saturation: err_count and wrap_count stop at all-ones and never roll over.
- Priority within one sample: restart > correct > mismatch. Exactly one of seq_error, restart_pulse or (correct) applies per sample.
- locked is decoded from the registered state, so it has no extra latency beyond the state update.

Decomposition:
- contador_pkg holds:
  - the monitor_state_t enum (IDLE, ACQUIRE, LOCKED, LOST; 2 bits)
  - the default WIDTH, LOCK_CNT and LOSS_CNT constants, shared with contador_sequencial.
- Sub-module sat_counter: parameterised width, inc input, async active-low reset. Instantiated twice, for err_count and wrap_count.

Test Plan:
- Lock: reset 0->1, then valid count_in 0,1,2,3 -> state IDLE→ACQUIRE after 0; locked=1 after sample 3; err_count=0.
- Full sweep: 0..15,0,1 while valid -> exactly one wrap_pulse, on sample 0; wrap_count=1; locked stays 1.
- Single glitch: locked, samples 4,9,10,11 -> one seq_error, on 9; err_count=1; locked stays 1 (miss resets on 10).
- Loss and relock: locked, samples 5,10,12,13,14,15 -> seq_error on 10 and 12; err_count=2; state LOST after 12; LOCKED again after 15.
- Restart and hold: locked at 7, then count_valid=0 for 3 cycles with count_in=0, then valid 0 -> no activity during hold; restart_pulse on the valid 0; err_count unchanged; state ACQUIRE.
- Mid-operation reset and saturation:
  - reset asserted between clk edges -> all outputs 0 immediately.
  - Separately, 300 forced mismatches -> err_count holds at 255.
